game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/wam_pkg.sv | 13 +
 rtl/bcd_sat_inc.sv | 22 ++
 rtl/game_ctrl.sv | 105 ++++++++++
 tb/tb_game_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared constants for the whack-a-mole game controller: FSM encodings
// and round/score limits.
package wam_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ARM  = 2'b01;
  localparam logic [1:0] ST_PLAY = 2'b10;
  localparam logic [1:0] ST_OVER = 2'b11;

  localparam int unsigned DEF_GAME_SECONDS  = 60;
  localparam logic [7:0]  DEF_SCORE_MAX_BCD = 8'h99;

endpackage

// File: rtl/bcd_sat_inc.sv
// Two-digit BCD incrementer that saturates at MAX_BCD.
module bcd_sat_inc
  import wam_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = DEF_SCORE_MAX_BCD
) (
  input  logic [7:0] i_bcd,
  output logic [7:0] o_bcd
);

  always_comb begin
    o_bcd = i_bcd;
    if (i_bcd < MAX_BCD) begin
      if (i_bcd[3:0] == 4'd9) begin
        o_bcd = {i_bcd[7:4] + 4'd1, 4'd0};
      end else begin
        o_bcd = {i_bcd[7:4], i_bcd[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game round controller: start/hit edge detection, IDLE/ARM/PLAY/OVER FSM,
// BCD score and best-score tracking. All outputs are registered.
module game_ctrl
  import wam_pkg::*;
#(
  parameter int unsigned GAME_SECONDS  = DEF_GAME_SECONDS,
  parameter logic [7:0]  SCORE_MAX_BCD = DEF_SCORE_MAX_BCD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_key,
  input  logic       hit_key,
  input  logic [5:0] time_left,
  output logic       timer_enable,
  output logic       timer_clear_n,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] state,
  output logic       game_over
);

  logic       r_start_low;
  logic       r_hit_low;
  logic       r_guard;
  logic [1:0] r_state;
  logic [7:0] r_score;
  logic [7:0] r_high;
  logic       r_timer_en;
  logic       r_clear_n;
  logic       r_over;

  logic       w_start_edge;
  logic       w_hit_edge;
  logic [1:0] w_state_nxt;
  logic [7:0] w_score_inc;
  logic [7:0] w_score_nxt;

  // Edge flops hold "key was low last cycle" so their reset value of 0
  // suppresses an event for a key held high through reset.
  assign w_start_edge = start_key & r_start_low;
  assign w_hit_edge   = hit_key & r_hit_low;

  bcd_sat_inc #(
    .MAX_BCD(SCORE_MAX_BCD)
  ) u_inc (
    .i_bcd(r_score),
    .o_bcd(w_score_inc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_edge) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_state_nxt = ST_PLAY;
      end
      default: begin
        if (w_hit_edge) w_score_nxt = w_score_inc;
        if (r_guard && (time_left == '0)) w_state_nxt = ST_OVER;
      end
    endcase
    if (w_state_nxt == ST_ARM) w_score_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_high      <= '0;
      r_start_low <= 1'b0;
      r_hit_low   <= 1'b0;
      r_guard     <= 1'b0;
      r_timer_en  <= 1'b0;
      r_clear_n   <= 1'b1;
      r_over      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_start_low <= ~start_key;
      r_hit_low   <= ~hit_key;
      r_guard     <= (r_state == ST_PLAY);
      r_timer_en  <= (w_state_nxt == ST_PLAY);
      r_clear_n   <= (w_state_nxt != ST_ARM);
      r_over      <= (w_state_nxt == ST_OVER);
      // Best score is taken from the final score on the PLAY->OVER edge so it
      // is already valid on the first OVER cycle.
      if ((r_state == ST_PLAY) && (w_state_nxt == ST_OVER) && (w_score_nxt > r_high))
        r_high <= w_score_nxt;
    end
  end

  a_time_range: assert property (@(posedge clk) disable iff (!reset)
    int'(time_left) <= int'(GAME_SECONDS));

  assign state         = r_state;
  assign score         = r_score;
  assign high_score    = r_high;
  assign timer_enable  = r_timer_en;
  assign timer_clear_n = r_clear_n;
  assign game_over     = r_over;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expectations are queued as stimulus is
// driven and compared against the outputs after the clock edge.
module tb_game_ctrl;
  import wam_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_key;
  logic       hit_key;
  logic [5:0] time_left;
  logic       timer_enable;
  logic       timer_clear_n;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] state;
  logic       game_over;

  localparam int unsigned SEL_STATE = 0;
  localparam int unsigned SEL_EN    = 1;
  localparam int unsigned SEL_CLR   = 2;
  localparam int unsigned SEL_SCORE = 3;
  localparam int unsigned SEL_HIGH  = 4;
  localparam int unsigned SEL_OVER  = 5;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [7:0]  val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hits  = 0;

  game_ctrl #(
    .GAME_SECONDS (60),
    .SCORE_MAX_BCD(8'h99)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_key    (start_key),
    .hit_key      (hit_key),
    .time_left    (time_left),
    .timer_enable (timer_enable),
    .timer_clear_n(timer_clear_n),
    .score        (score),
    .high_score   (high_score),
    .state        (state),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observe(input int unsigned sel);
    case (sel)
      SEL_STATE: return {6'd0, state};
      SEL_EN:    return {7'd0, timer_enable};
      SEL_CLR:   return {7'd0, timer_clear_n};
      SEL_SCORE: return score;
      SEL_HIGH:  return high_score;
      default:   return {7'd0, game_over};
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    int m;
    m = (n > 99) ? 99 : n;
    r[7:4] = 4'(m / 10);
    r[3:0] = 4'(m % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_all(input string tag, input logic [1:0] st, input logic en,
                          input logic clr, input logic [7:0] sc, input logic [7:0] hi,
                          input logic ov);
    push({tag, ".state"}, SEL_STATE, {6'd0, st});
    push({tag, ".timer_enable"}, SEL_EN, {7'd0, en});
    push({tag, ".timer_clear_n"}, SEL_CLR, {7'd0, clr});
    push({tag, ".score"}, SEL_SCORE, sc);
    push({tag, ".high_score"}, SEL_HIGH, hi);
    push({tag, ".game_over"}, SEL_OVER, {7'd0, ov});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_round(input logic [7:0] hi);
    start_key = 1'b1;
    push_all("arm", ST_ARM, 1'b0, 1'b0, 8'h00, hi, 1'b0);
    tick();
    drain();
    start_key = 1'b0;
    push_all("play", ST_PLAY, 1'b1, 1'b1, 8'h00, hi, 1'b0);
    tick();
    drain();
    hits = 0;
  endtask

  task automatic run_hits(input int n);
    for (int i = 0; i < n; i++) begin
      hits++;
      push("hit.score", SEL_SCORE, to_bcd(hits));
      hit_key = 1'b1;
      tick();
      hit_key = 1'b0;
      tick();
      drain();
    end
  endtask

  task automatic end_round(input logic [7:0] hi);
    time_left = 6'd0;
    push_all("over", ST_OVER, 1'b0, 1'b1, to_bcd(hits), hi, 1'b1);
    tick();
    drain();
    time_left = 6'd30;
  endtask

  task automatic hit_in_over();
    push("over_hit.score", SEL_SCORE, to_bcd(hits));
    push("over_hit.state", SEL_STATE, {6'd0, ST_OVER});
    hit_key = 1'b1;
    tick();
    hit_key = 1'b0;
    tick();
    drain();
  endtask

  initial begin
    reset     = 1'b0;
    start_key = 1'b0;
    hit_key   = 1'b0;
    time_left = 6'd30;
    tick();
    tick();
    push_all("reset", ST_IDLE, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    drain();
    reset = 1'b1;
    tick();

    // Round 1: 12 hits, best score becomes 12
    start_round(8'h00);
    run_hits(12);
    end_round(8'h12);
    hit_in_over();

    // Round 2: 7 hits, best score unchanged
    start_round(8'h12);
    run_hits(7);
    end_round(8'h12);

    // Round 3: saturation at 99 across all BCD carries
    start_round(8'h12);
    run_hits(105);
    end_round(8'h99);

    // Round 4: guard cycle, start ignored in PLAY, hit on the final cycle
    start_key = 1'b1;
    push("r4.arm", SEL_STATE, {6'd0, ST_ARM});
    tick();
    drain();
    start_key = 1'b0;
    time_left = 6'd0;
    push("r4.play", SEL_STATE, {6'd0, ST_PLAY});
    tick();
    drain();
    push("r4.guard", SEL_STATE, {6'd0, ST_PLAY});
    tick();
    drain();
    time_left = 6'd30;
    hits = 0;
    start_key = 1'b1;
    push("r4.start_in_play", SEL_STATE, {6'd0, ST_PLAY});
    tick();
    drain();
    start_key = 1'b0;
    tick();
    run_hits(3);
    hit_key   = 1'b1;
    time_left = 6'd0;
    hits++;
    push_all("r4.last_hit", ST_OVER, 1'b0, 1'b1, 8'h04, 8'h99, 1'b1);
    tick();
    drain();
    hit_key   = 1'b0;
    time_left = 6'd30;
    tick();
    hit_in_over();

    // Round 5: reset mid-PLAY with start held through reset
    start_round(8'h99);
    run_hits(5);
    start_key = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    push_all("mid_reset", ST_IDLE, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    drain();
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    push_all("held_start", ST_IDLE, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    drain();
    start_key = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
